mips_mc_ctrl: RTL

Parametrised multicycle MIPS main controller: the successor to the fixed-latency controller. It adds a memory ready handshake with variable wait states and extends the instruction set with bne, addi, andi, ori and j. It drives the existing multicycle datapath control bundle plus memreq, and sits between the instruction register (op/funct) and the datapath inside the mips top.

---
 rtl/mips_mc_pkg.sv | 81 ++++++++
 rtl/mips_mc_ctrl_if.sv | 45 ++++
 rtl/mips_mc_aludec.sv | 39 +++
 rtl/mips_mc_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS controller
//
// Purpose : FSM state enum, ALU-op selector enum, opcode/funct codes and the
//           alucontrol / alusrcb / pcsrc encodings used by mips_mc_ctrl.
// Ports   : none (package).
// Config  : MIPS_MC_TIMEOUT_EN adds the s_error state to the state enum.

package mips_mc_pkg;

   typedef enum logic [3:0] {
      s_fetch,
      s_decode,
      s_memadr,
      s_memrd,
      s_memwb,
      s_memwr,
      s_rtex,
      s_rtwb,
      s_beqex,
      s_bneex,
      s_addiex,
      s_andiex,
      s_oriex,
      s_immwb,
      s_jex
`ifdef MIPS_MC_TIMEOUT_EN
      , s_error
`endif
   } state_t;

   // Operation the FSM asks of the ALU decoder; aluop_funct defers to funct.
   typedef enum logic [2:0] {
      aluop_add,
      aluop_sub,
      aluop_and,
      aluop_or,
      aluop_funct
   } aluop_t;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // alucontrol encodings
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // alusrcb encodings
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // pcsrc encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold a memory access open until memready.
   function automatic logic is_mem_state(input state_t s);
      return (s == s_fetch) || (s == s_memrd) || (s == s_memwr);
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// rtl/mips_mc_ctrl_if.sv - controller <-> IR/datapath/memory signal bundle
//
// Purpose : groups the instruction fields, status inputs and the multicycle
//           datapath control bundle between mips_mc_ctrl and the mips top.
// Signals : op[5:0], funct[5:0], zero, memready      (into the controller)
//           memreq, memwrite, irwrite, pcen, regwrite, alusrca, iord,
//           memtoreg, regdst, immext, alusrcb[1:0], pcsrc[1:0],
//           alucontrol[2:0], buserr                  (out of the controller)
// Modports: master = controller side, slave = datapath/memory side.

interface mips_mc_ctrl_if;

   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;

   logic       memreq;
   logic       memwrite;
   logic       irwrite;
   logic       pcen;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       immext;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       buserr;

   modport master (
      input  op, funct, zero, memready,
      output memreq, memwrite, irwrite, pcen, regwrite, alusrca, iord,
             memtoreg, regdst, immext, alusrcb, pcsrc, alucontrol, buserr
   );

   modport slave (
      output op, funct, zero, memready,
      input  memreq, memwrite, irwrite, pcen, regwrite, alusrca, iord,
             memtoreg, regdst, immext, alusrcb, pcsrc, alucontrol, buserr
   );

endinterface

// File: rtl/mips_mc_aludec.sv
// rtl/mips_mc_aludec.sv - ALU decoder for the multicycle controller
//
// Purpose : maps the FSM's ALU-op selector (and funct for R-type) to the
//           3-bit alucontrol code.
// Ports   : aluop      in  aluop_t  operation requested by the FSM
//           funct      in  6        instr[5:0]
//           alucontrol out 3        ALU operation code

module mips_mc_aludec
   import mips_mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         aluop_add: alucontrol = ALU_ADD;
         aluop_sub: alucontrol = ALU_SUB;
         aluop_and: alucontrol = ALU_AND;
         aluop_or:  alucontrol = ALU_OR;
         aluop_funct: begin
            // Unrecognised funct codes fall back to add.
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS main controller with memory ready handshake
//
// Purpose : Moore FSM driving the multicycle datapath. Memory states (fetch,
//           load, store) hold their request until memready. Supports
//           R-type, lw, sw, beq, bne, addi, andi, ori and j; any other
//           opcode retires as a two-cycle NOP.
// Params  : WAIT_LIMIT  wait cycles before a bus timeout (timeout build only)
//           CNT_W       wait counter width, derived from WAIT_LIMIT
// Ports   : clk    in  system clock
//           reset  in  asynchronous active-high reset
//           bus    mips_mc_ctrl_if.master (op, funct, zero, memready in;
//                  datapath control bundle, memreq and buserr out)
// Config  : MIPS_MC_TIMEOUT_EN builds the wait counter and the sticky
//           s_error state; otherwise waits are unbounded and buserr is 0.

module mips_mc_ctrl
   import mips_mc_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = $clog2(WAIT_LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   mips_mc_ctrl_if.master bus
);

   if (WAIT_LIMIT < 1 || CNT_W != $clog2(WAIT_LIMIT + 1)) begin : g_bad_param
      $error("mips_mc_ctrl: WAIT_LIMIT must be >= 1 and CNT_W is derived from it");
   end

   state_t state, state_n;
   state_t wait_next;   // where a memory state goes when memready is low
   aluop_t aluop;

   logic memreq, memwrite, irwrite, pcen, regwrite;
   logic alusrca, iord, memtoreg, regdst, immext;
   logic [1:0] alusrcb, pcsrc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= s_fetch;
      else       state <= state_n;
   end

`ifdef MIPS_MC_TIMEOUT_EN
   logic [CNT_W-1:0] wcnt;
   logic             timeout;

   // The wait that would bring the count to WAIT_LIMIT is the timeout;
   // a memready in that same cycle still completes the access.
   assign timeout   = ~bus.memready && (wcnt == CNT_W'(WAIT_LIMIT - 1));
   assign wait_next = timeout ? s_error : state;

   // Any state change clears the count, so every entry into a memory
   // state starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wcnt <= '0;
      else if (state_n != state)
         wcnt <= '0;
      else if (is_mem_state(state) && !bus.memready && wcnt != CNT_W'(WAIT_LIMIT))
         wcnt <= wcnt + 1'b1;
   end

   // s_error is only left through reset, which makes this flag sticky.
   assign bus.buserr = (state == s_error);
`else
   assign wait_next  = state;
   assign bus.buserr = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      aluop    = aluop_add;
      memreq   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      immext   = 1'b0;
      alusrcb  = SRCB_B;
      pcsrc    = PCSRC_ALU;

      case (state)
         s_fetch: begin
            memreq  = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = bus.memready;
            pcen    = bus.memready;
            state_n = bus.memready ? s_decode : wait_next;
         end
         s_decode: begin
            // Precompute the branch target into ALUOut.
            alusrcb = SRCB_IMMSH;
            case (bus.op)
               OP_LW, OP_SW: state_n = s_memadr;
               OP_RTYPE:     state_n = s_rtex;
               OP_BEQ:       state_n = s_beqex;
               OP_BNE:       state_n = s_bneex;
               OP_ADDI:      state_n = s_addiex;
               OP_ANDI:      state_n = s_andiex;
               OP_ORI:       state_n = s_oriex;
               OP_J:         state_n = s_jex;
               default:      state_n = s_fetch;
            endcase
         end
         s_memadr: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_n = (bus.op == OP_SW) ? s_memwr : s_memrd;
         end
         s_memrd: begin
            memreq  = 1'b1;
            iord    = 1'b1;
            state_n = bus.memready ? s_memwb : wait_next;
         end
         s_memwb: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_n  = s_fetch;
         end
         s_memwr: begin
            memreq   = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            state_n  = bus.memready ? s_fetch : wait_next;
         end
         s_rtex: begin
            alusrca = 1'b1;
            aluop   = aluop_funct;
            state_n = s_rtwb;
         end
         s_rtwb: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_n  = s_fetch;
         end
         s_beqex, s_bneex: begin
            alusrca = 1'b1;
            aluop   = aluop_sub;
            pcsrc   = PCSRC_ALUOUT;
            pcen    = (state == s_beqex) ? bus.zero : ~bus.zero;
            state_n = s_fetch;
         end
         s_addiex: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_n = s_immwb;
         end
         s_andiex: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = aluop_and;
            immext  = 1'b1;
            state_n = s_immwb;
         end
         s_oriex: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = aluop_or;
            immext  = 1'b1;
            state_n = s_immwb;
         end
         s_immwb: begin
            regwrite = 1'b1;
            state_n  = s_fetch;
         end
         s_jex: begin
            pcsrc   = PCSRC_JUMP;
            pcen    = 1'b1;
            state_n = s_fetch;
         end
`ifdef MIPS_MC_TIMEOUT_EN
         s_error: state_n = s_error;
`endif
         default: state_n = s_fetch;
      endcase
   end

   mips_mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (bus.funct),
      .alucontrol (bus.alucontrol)
   );

   // Strobes are forced low while reset is held; the state register already
   // sits in s_fetch, so the mux selects show their fetch values.
   assign bus.memreq   = memreq   & ~reset;
   assign bus.memwrite = memwrite & ~reset;
   assign bus.irwrite  = irwrite  & ~reset;
   assign bus.pcen     = pcen     & ~reset;
   assign bus.regwrite = regwrite & ~reset;
   assign bus.alusrca  = alusrca;
   assign bus.iord     = iord;
   assign bus.memtoreg = memtoreg;
   assign bus.regdst   = regdst;
   assign bus.immext   = immext;
   assign bus.alusrcb  = alusrcb;
   assign bus.pcsrc    = pcsrc;

endmodule
